// File: rtl/fft_frame_buffer_if.sv
// Handshake and data bundle for fft_frame_buffer.
// The slave modport is the buffer's view; the master modport is the upstream/downstream environment.
interface fft_frame_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 32
);
   localparam int CNT_W = $clog2(NUM_CH);

   logic                         mode_ser_in;
   logic                         mode_ser_out;
   logic                         s_valid;
   logic                         s_ready;
   logic [DATA_WIDTH-1:0]        s_data_ser;
   logic [NUM_CH*DATA_WIDTH-1:0] s_data_par;
   logic                         m_valid;
   logic                         m_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] m_data_par;
   logic [DATA_WIDTH-1:0]        m_data_ser;
   logic [CNT_W-1:0]             m_index;
   logic                         m_last;

   modport master (
      output mode_ser_in, mode_ser_out, s_valid, s_data_ser, s_data_par, m_ready,
      input  s_ready, m_valid, m_data_par, m_data_ser, m_index, m_last
   );

   modport slave (
      input  mode_ser_in, mode_ser_out, s_valid, s_data_ser, s_data_par, m_ready,
      output s_ready, m_valid, m_data_par, m_data_ser, m_index, m_last
   );
endinterface

// File: rtl/fft_frame_buffer.sv
// One-frame sample buffer with valid/ready on both sides; loads a frame in parallel or
// serially and presents it in parallel or drains it serially, mode latched per frame.
module fft_frame_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   fft_frame_buffer_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_CH);
   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_CH - 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
   logic                  mode_in_q, mode_in_d;
   logic                  mode_out_q, mode_out_d;
   logic [DATA_WIDTH-1:0] bank_q [NUM_CH];
   logic [DATA_WIDTH-1:0] bank_d [NUM_CH];

   logic                         s_ready_s, m_valid_s, m_last_s;
   logic [DATA_WIDTH-1:0]        m_data_ser_s;
   logic [CNT_W-1:0]             m_index_s;
   logic [NUM_CH*DATA_WIDTH-1:0] m_data_par_s;
   logic                         s_fire_s, frame_start_s, in_ser_s, out_ser_s;

   // Output-side decode; HOLD accepts a new parallel frame only when the current one leaves.
   always_comb begin
      s_ready_s    = 1'b0;
      m_valid_s    = 1'b0;
      m_last_s     = 1'b0;
      m_data_ser_s = {DATA_WIDTH{1'b0}};
      m_index_s    = IDX_ZERO;
      case (state_q)
         ST_FILL: begin
            s_ready_s = 1'b1;
         end
         ST_HOLD: begin
            m_valid_s = 1'b1;
            m_last_s  = 1'b1;
            s_ready_s = bus.m_ready && !bus.mode_ser_in;
         end
         ST_DRAIN: begin
            m_valid_s    = 1'b1;
            m_last_s     = (rd_idx_q == IDX_LAST);
            m_data_ser_s = bank_q[rd_idx_q];
            m_index_s    = rd_idx_q;
         end
         default: begin
            s_ready_s = 1'b0;
         end
      endcase
   end

   // Pack the bank onto the parallel output bus.
   always_comb begin
      m_data_par_s = {(NUM_CH*DATA_WIDTH){1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         m_data_par_s[i*DATA_WIDTH +: DATA_WIDTH] = bank_q[i];
      end
   end

   assign bus.s_ready    = rst ? 1'b0 : s_ready_s;
   assign bus.m_valid    = rst ? 1'b0 : m_valid_s;
   assign bus.m_last     = m_last_s;
   assign bus.m_data_ser = m_data_ser_s;
   assign bus.m_index    = m_index_s;
   assign bus.m_data_par = m_data_par_s;

   assign s_fire_s      = bus.s_valid && bus.s_ready;
   assign frame_start_s = s_fire_s && (((state_q == ST_FILL) && (wr_idx_q == IDX_ZERO)) ||
                                       (state_q == ST_HOLD));
   assign in_ser_s      = frame_start_s ? bus.mode_ser_in  : mode_in_q;
   assign out_ser_s     = frame_start_s ? bus.mode_ser_out : mode_out_q;

   // Next-state logic; flush wins over any coincident beat and leaves the bank alone.
   always_comb begin
      state_d    = state_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      mode_in_d  = mode_in_q;
      mode_out_d = mode_out_q;
      for (int i = 0; i < NUM_CH; i++) begin
         bank_d[i] = bank_q[i];
      end
      if (flush) begin
         state_d  = ST_FILL;
         wr_idx_d = IDX_ZERO;
         rd_idx_d = IDX_ZERO;
      end else begin
         if (frame_start_s) begin
            mode_in_d  = bus.mode_ser_in;
            mode_out_d = bus.mode_ser_out;
         end else begin
            mode_in_d  = mode_in_q;
            mode_out_d = mode_out_q;
         end
         case (state_q)
            ST_FILL: begin
               if (s_fire_s && in_ser_s) begin
                  bank_d[wr_idx_q] = bus.s_data_ser;
                  if (wr_idx_q == IDX_LAST) begin
                     wr_idx_d = IDX_ZERO;
                     state_d  = out_ser_s ? ST_DRAIN : ST_HOLD;
                  end else begin
                     wr_idx_d = wr_idx_q + IDX_ONE;
                  end
               end else if (s_fire_s) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     bank_d[i] = bus.s_data_par[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  state_d = out_ser_s ? ST_DRAIN : ST_HOLD;
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_HOLD: begin
               if (bus.m_ready && s_fire_s) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     bank_d[i] = bus.s_data_par[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  state_d = out_ser_s ? ST_DRAIN : ST_HOLD;
               end else if (bus.m_ready) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_DRAIN: begin
               if (bus.m_ready && (rd_idx_q == IDX_LAST)) begin
                  rd_idx_d = IDX_ZERO;
                  state_d  = ST_FILL;
               end else if (bus.m_ready) begin
                  rd_idx_d = rd_idx_q + IDX_ONE;
               end else begin
                  rd_idx_d = rd_idx_q;
               end
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase
      end
   end

   // State and bank registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FILL;
         wr_idx_q   <= IDX_ZERO;
         rd_idx_q   <= IDX_ZERO;
         mode_in_q  <= 1'b0;
         mode_out_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            bank_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         mode_in_q  <= mode_in_d;
         mode_out_q <= mode_out_d;
         for (int i = 0; i < NUM_CH; i++) begin
            bank_q[i] <= bank_d[i];
         end
      end
   end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed-plus-random bench for fft_frame_buffer: a 32x16 instance and an 8x24 instance.
module tb_fft_frame_buffer;
   localparam int DW  = 16;
   localparam int NC  = 32;
   localparam int DWB = 24;
   localparam int NCB = 8;
   localparam int FW  = NC * DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_a = 1'b0;
   logic flush_b = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   fft_frame_buffer_if #(.DATA_WIDTH(DW),  .NUM_CH(NC))  bus_a ();
   fft_frame_buffer_if #(.DATA_WIDTH(DWB), .NUM_CH(NCB)) bus_b ();

   fft_frame_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut_a (
      .clk(clk), .rst(rst), .flush(flush_a), .bus(bus_a));
   fft_frame_buffer #(.DATA_WIDTH(DWB), .NUM_CH(NCB)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .bus(bus_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      for (int i = 0; i < NC; i++) f[i*DW +: DW] = DW'($urandom);
      return f;
   endfunction

   // Offer one frame; serial loads use random gaps and scramble the mode inputs after the first beat.
   task automatic load_frame(input bit ser_in, input bit ser_out, input logic [FW-1:0] f);
      int k = 0;
      int guard = 0;
      if (!ser_in) begin
         bus_a.s_valid = 1'b1;
         bus_a.mode_ser_in = 1'b0;
         bus_a.mode_ser_out = ser_out;
         bus_a.s_data_par = f;
         @(negedge clk);
         chk("par_load_s_ready", FW'(bus_a.s_ready), FW'(1));
         chk("par_load_m_valid", FW'(bus_a.m_valid), FW'(0));
         cyc();
      end else begin
         while (k < NC && guard < 400) begin
            bus_a.s_valid = ($urandom_range(0, 3) != 0);
            bus_a.mode_ser_in = (k == 0) ? 1'b1 : 1'($urandom);
            bus_a.mode_ser_out = (k == 0) ? ser_out : 1'($urandom);
            bus_a.s_data_ser = f[k*DW +: DW];
            @(negedge clk);
            chk("ser_fill_m_valid", FW'(bus_a.m_valid), FW'(0));
            chk("ser_fill_s_ready", FW'(bus_a.s_ready), FW'(1));
            @(posedge clk);
            if (bus_a.s_valid) k++;
            guard++;
            #1;
         end
         if (k != NC) chk("ser_fill_timeout", FW'(k), FW'(NC));
      end
      bus_a.s_valid = 1'b0;
      bus_a.mode_ser_in = 1'b0;
      bus_a.mode_ser_out = 1'b0;
   endtask

   // Consume one frame and compare against the frame that was offered.
   task automatic consume_check(input bit ser_out, input bit toggle, input logic [FW-1:0] f);
      int idx = 0;
      int guard = 0;
      if (!ser_out) begin
         int nstall = $urandom_range(0, 2);
         for (int j = 0; j <= nstall; j++) begin
            bus_a.m_ready = (j == nstall);
            @(negedge clk);
            chk("par_m_valid", FW'(bus_a.m_valid), FW'(1));
            chk("par_m_last", FW'(bus_a.m_last), FW'(1));
            chk("par_m_data", bus_a.m_data_par, f);
            chk("par_m_data_ser", FW'(bus_a.m_data_ser), FW'(0));
            cyc();
         end
      end else begin
         while (idx < NC && guard < 200) begin
            bus_a.m_ready = toggle ? (guard % 2 == 0) : 1'($urandom);
            @(negedge clk);
            chk("drain_m_valid", FW'(bus_a.m_valid), FW'(1));
            chk("drain_s_ready", FW'(bus_a.s_ready), FW'(0));
            chk("drain_m_index", FW'(bus_a.m_index), FW'(idx));
            chk("drain_m_data_ser", FW'(bus_a.m_data_ser), FW'(f[idx*DW +: DW]));
            chk("drain_m_last", FW'(bus_a.m_last), FW'(idx == NC - 1));
            @(posedge clk);
            if (bus_a.m_ready) idx++;
            guard++;
            #1;
         end
         if (idx != NC) chk("drain_timeout", FW'(idx), FW'(NC));
      end
      bus_a.m_ready = 1'b0;
      @(negedge clk);
      chk("after_frame_m_valid", FW'(bus_a.m_valid), FW'(0));
      chk("after_frame_bank", bus_a.m_data_par, f);
      cyc();
   endtask

   initial begin
      logic [FW-1:0] f0, f1, f2, f3, g;
      logic [DWB-1:0] smp_b [NCB];
      int k;

      bus_a.s_valid = 1'b0; bus_a.m_ready = 1'b0; bus_a.mode_ser_in = 1'b0;
      bus_a.mode_ser_out = 1'b0; bus_a.s_data_ser = '0; bus_a.s_data_par = '0;
      bus_b.s_valid = 1'b0; bus_b.m_ready = 1'b0; bus_b.mode_ser_in = 1'b0;
      bus_b.mode_ser_out = 1'b0; bus_b.s_data_ser = '0; bus_b.s_data_par = '0;

      // 1: reset then parallel-in/parallel-out
      cyc(); cyc();
      @(negedge clk);
      chk("rst_s_ready", FW'(bus_a.s_ready), FW'(0));
      chk("rst_m_valid", FW'(bus_a.m_valid), FW'(0));
      chk("rst_m_data_par", bus_a.m_data_par, FW'(0));
      chk("rst_m_index", FW'(bus_a.m_index), FW'(0));
      chk("rst_m_last", FW'(bus_a.m_last), FW'(0));
      cyc();
      rst = 1'b0;
      for (int i = 0; i < NC; i++) f0[i*DW +: DW] = DW'(i + 1);
      load_frame(1'b0, 1'b0, f0);
      consume_check(1'b0, 1'b0, f0);

      // 2 and 6a: serial-in with ignored mode changes, parallel-out
      for (int i = 0; i < NC; i++) f1[i*DW +: DW] = DW'(16'h0100 + i);
      load_frame(1'b1, 1'b0, f1);
      consume_check(1'b0, 1'b0, f1);

      // 3: parallel-in, serial-out with m_ready toggling
      for (int i = 0; i < NC; i++) f2[i*DW +: DW] = DW'(16'hA000 + i);
      load_frame(1'b0, 1'b1, f2);
      consume_check(1'b1, 1'b1, f2);

      // 4: back-to-back parallel frames
      f0 = rand_frame(); f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
      bus_a.m_ready = 1'b1; bus_a.s_valid = 1'b1;
      bus_a.mode_ser_in = 1'b0; bus_a.mode_ser_out = 1'b0;
      bus_a.s_data_par = f0;
      @(negedge clk);
      chk("b2b_s_ready0", FW'(bus_a.s_ready), FW'(1));
      chk("b2b_m_valid0", FW'(bus_a.m_valid), FW'(0));
      cyc();
      bus_a.s_data_par = f1;
      @(negedge clk);
      chk("b2b_valid_f0", FW'(bus_a.m_valid), FW'(1));
      chk("b2b_data_f0", bus_a.m_data_par, f0);
      chk("b2b_s_ready_f0", FW'(bus_a.s_ready), FW'(1));
      cyc();
      bus_a.s_data_par = f2;
      @(negedge clk);
      chk("b2b_valid_f1", FW'(bus_a.m_valid), FW'(1));
      chk("b2b_data_f1", bus_a.m_data_par, f1);
      cyc();
      bus_a.s_data_par = f3;
      bus_a.m_ready = 1'b0;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk("b2b_stall_valid", FW'(bus_a.m_valid), FW'(1));
         chk("b2b_stall_s_ready", FW'(bus_a.s_ready), FW'(0));
         chk("b2b_stall_data_f2", bus_a.m_data_par, f2);
         cyc();
      end
      bus_a.s_valid = 1'b0;
      consume_check(1'b0, 1'b0, f2);

      // 5: flush mid serial fill, then a fresh full serial frame
      bus_a.mode_ser_in = 1'b1; bus_a.mode_ser_out = 1'b1; bus_a.s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_a.s_data_ser = DW'($urandom);
         cyc();
      end
      flush_a = 1'b1;
      cyc();
      flush_a = 1'b0;
      bus_a.s_valid = 1'b0;
      g = rand_frame();
      load_frame(1'b1, 1'b0, g);
      consume_check(1'b0, 1'b0, g);

      // 5b: reset mid-drain
      g = rand_frame();
      load_frame(1'b0, 1'b1, g);
      bus_a.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      bus_a.m_ready = 1'b0;
      rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("rst_drain_s_ready", FW'(bus_a.s_ready), FW'(0));
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_m_valid", FW'(bus_a.m_valid), FW'(0));
      chk("post_rst_s_ready", FW'(bus_a.s_ready), FW'(1));
      chk("post_rst_bank", bus_a.m_data_par, FW'(0));
      chk("post_rst_m_index", FW'(bus_a.m_index), FW'(0));
      cyc();

      // random mode round trips
      for (int r = 0; r < 4; r++) begin
         bit si, so;
         si = 1'($urandom); so = 1'($urandom);
         g = rand_frame();
         load_frame(si, so, g);
         consume_check(so, 1'b0, g);
      end

      // 6b: 8 x 24-bit serial round trip, out-mode toggled after the first beat
      for (int i = 0; i < NCB; i++) smp_b[i] = DWB'($urandom);
      bus_b.s_valid = 1'b1;
      for (int i = 0; i < NCB; i++) begin
         bus_b.mode_ser_in = (i == 0) ? 1'b1 : 1'($urandom);
         bus_b.mode_ser_out = (i == 0) ? 1'b1 : 1'b0;
         bus_b.s_data_ser = smp_b[i];
         cyc();
      end
      bus_b.s_valid = 1'b0;
      bus_b.m_ready = 1'b1;
      k = 0;
      while (k < NCB) begin
         @(negedge clk);
         chk("b_m_valid", FW'(bus_b.m_valid), FW'(1));
         chk("b_m_index", FW'(bus_b.m_index), FW'(k));
         chk("b_m_data_ser", FW'(bus_b.m_data_ser), FW'(smp_b[k]));
         chk("b_m_last", FW'(bus_b.m_last), FW'(k == NCB - 1));
         cyc();
         k++;
      end
      bus_b.m_ready = 1'b0;
      @(negedge clk);
      chk("b_after_m_valid", FW'(bus_b.m_valid), FW'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Parametrised successor to the fixed 32-word FFT stage register. Holds one frame of NUM_CH samples between FFT stages or at the FFT boundary.
- Adds valid/ready handshakes on both sides.
- Input side: parallel load (whole frame in one beat) or serial load (one sample per beat).
- Output side: parallel present or serial drain, selected per frame. Serves as input deserialiser, inter-stage pipeline register or output serialiser.

Parameters:
- DATA_WIDTH, 16, bits per sample (complex packing is the caller's concern).
- NUM_CH, 32, samples per frame; must be ≥2.
- CNT_W, $clog2(NUM_CH), index counter width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of current frame; data bank not cleared.
- mode_ser_in  in  1  1 = serial load, 0 = parallel load; latched at frame start.
- mode_ser_out  in  1  1 = serial drain, 0 = parallel present; latched at frame start.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data_ser  in  DATA_WIDTH  serial input sample.
- s_data_par  in  NUM_CH*DATA_WIDTH  parallel input frame; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accept.
- m_data_par  out  NUM_CH*DATA_WIDTH  registered bank contents, same packing as input.
- m_data_ser  out  DATA_WIDTH  bank[rd_idx] during serial drain, else 0.
- m_index  out  CNT_W  rd_idx during serial drain, else 0.
- m_last  out  1  high with the final serial beat (rd_idx == NUM_CH-1) and with every parallel beat.

Behaviour:
- Reset (rst high at an edge):
  - All bank words = 0; wr_idx = 0; rd_idx = 0; state = FILL; latched modes = 0.
  - s_ready and m_valid are forced to 0 combinationally while rst is high. All other outputs are 0 after reset.
- Frame start: the first accepted beat in FILL with wr_idx == 0 latches mode_ser_in/mode_ser_out into mode_in_q/mode_out_q. Mode inputs are ignored for the rest of the frame.
- States:
  - FILL:
    - s_ready = 1; m_valid = 0.
    - Parallel beat: all NUM_CH words loaded at once; next state HOLD if out-mode parallel, DRAIN if serial.
    - Serial beat: bank[wr_idx] <= s_data_ser; wr_idx++. The beat with wr_idx == NUM_CH-1 wraps wr_idx to 0 and moves to HOLD or DRAIN.
  - HOLD:
    - m_valid = 1; m_last = 1; m_data_par = bank.
    - s_ready = m_ready && !mode_ser_in. This is a back-to-back parallel fast path, evaluated on the live mode input, which also becomes the new latched mode.
    - m_ready with no input beat → FILL.
    - m_ready with a simultaneous parallel input beat → new frame loaded, modes re-latched. Stays in HOLD if the new out-mode is parallel, else DRAIN.
  - DRAIN:
    - m_valid = 1; s_ready = 0; m_data_ser = bank[rd_idx]; m_index = rd_idx.
    - Each m_ready advances rd_idx. The beat at rd_idx == NUM_CH-1 asserts m_last, wraps rd_idx to 0, → FILL.
- Latency:
  - Parallel-in/parallel-out: m_valid high the cycle after acceptance (1 cycle), giving throughput of 1 frame/cycle with m_ready held high.
  - Serial-in: m_valid high the cycle after the NUM_CH-th accepted beat.
  - Serial-out: NUM_CH handshaked beats per frame.
- Handshake rules:
  - Once m_valid is high, it and all m_* data stay stable until m_ready.
  - Beats with s_valid && !s_ready are ignored with no state change.
- Flush:
  - wr_idx = rd_idx = 0; state = FILL; bank untouched.
  - Flush has priority over any coincident handshake, and that beat is discarded.
  - rst has priority over flush.
- Reset or flush mid-serial-fill or mid-drain: the partial frame is abandoned and the next accepted beat starts a fresh frame at index 0.
- Bank is written only on accepted input beats. m_data_par always reflects the bank, even in FILL.

Test Plan:
1. Reset, then parallel-in/parallel-out with s_data_par channel i = i+1 and m_ready = 1 → m_valid high 1 cycle later; m_data_par channel i = i+1; m_last = 1; s_ready = 0 during rst.
2. Serial-in with samples 0x0100..0x011F, then parallel-out → m_valid rises exactly 1 cycle after the 32nd accepted beat; channel 31 = 0x011F.
3. Parallel-in with channel i = 0xA000+i, serial-out, with m_ready toggling 1/0 → 32 beats, m_index 0..31 in order, m_data_ser = 0xA000+m_index, m_last only on index 31, outputs stable while m_ready = 0.
4. Back-to-back parallel frames F0, F1, F2 on consecutive cycles with m_ready = 1 → outputs F0, F1, F2 on consecutive cycles with m_valid continuously high; then m_ready = 0 stalls s_ready to 0 and holds F2.
5. Serial fill aborted by flush after 10 beats, then 32 new beats → frame equals the new 32 samples; wr_idx restarted at 0. Repeat with rst mid-drain → bank reads 0 and state is FILL.
6. mode_ser_out toggled mid serial-fill → ignored; out-mode latched at the first beat applies. Also non-default NUM_CH = 8, DATA_WIDTH = 24: serial round trip reproduces the 8 input samples.
